// File: rtl/serial_subtractor_nbit_pkg.sv
// serial_subtractor_nbit_pkg: shared FSM state encoding and default operand width
package serial_subtractor_nbit_pkg;
  localparam int DEF_W = 16;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_subtractor_nbit_fs.sv
// full_subtractor_1bit: combinational 1-bit full subtractor (x - y - bi -> d, borrow bo)
module full_subtractor_1bit (
  output logic d,
  output logic bo,
  input  logic x,
  input  logic y,
  input  logic bi
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor_nbit.sv
// serial_subtractor_nbit: LSB-first bit-serial {b_out,diff} = a - b - b_in with start/busy/done handshake
module serial_subtractor_nbit
  import serial_subtractor_nbit_pkg::*;
#(
  parameter int W = DEF_W,
  localparam int CW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         b_out
);
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_sa;
  logic [W-1:0]  r_sb;
  logic [W-1:0]  r_diff;
  logic          r_br;
  logic          w_d;
  logic          w_bo;
  logic          w_accept;
  full_subtractor_1bit u_fs (
    .d (w_d),
    .bo(w_bo),
    .x (r_sa[0]),
    .y (r_sb[0]),
    .bi(r_br)
  );
  always_comb begin
    w_accept = start && (r_state != ST_RUN);
    w_next   = (r_state == ST_RUN) ? ((r_cnt == CW'(W - 1)) ? ST_DONE : ST_RUN)
                                   : (start ? ST_RUN : ST_IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sa    <= '0;
      r_sb    <= '0;
      r_diff  <= '0;
      r_br    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_sa  <= a;
        r_sb  <= b;
        r_br  <= b_in;
        r_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        r_sa   <= r_sa >> 1;
        r_sb   <= r_sb >> 1;
        r_diff <= {w_d, r_diff[W-1:1]};
        r_br   <= w_bo;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end
  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign diff  = r_diff;
  assign b_out = r_br;
endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// tb_serial_subtractor_nbit: scoreboard bench for the bit-serial subtractor
module tb_serial_subtractor_nbit;
  localparam int W = 16;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         b_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;
  int           vectors = 0;
  int           miscompares = 0;
  logic [W:0]   sb[$];
  serial_subtractor_nbit #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .b_in (b_in),
    .busy (busy),
    .done (done),
    .diff (diff),
    .b_out(b_out)
  );
  always #5 clk = ~clk;
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
  endfunction
  always @(negedge clk) begin
    if (!rst && done) begin
      logic [W:0] exp;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got b_out=%0b diff=%h with no pending op", b_out, diff);
      end else begin
        exp = sb.pop_front();
        if ({busy, b_out, diff} !== {1'b0, exp}) begin
          miscompares++;
          $display("FAIL result: got busy=%0b b_out=%0b diff=%h, expected busy=0 b_out=%0b diff=%h",
                   busy, b_out, diff, exp[W], exp[W-1:0]);
        end
      end
    end
  end
  task automatic wait_done(output int lat);
    bit found = 0;
    lat = -1;
    for (int i = 1; i <= W + 4 && !found; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = i;
        found = 1;
      end
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: no done within %0d cycles", W + 4);
      if (sb.size() > 0) void'(sb.pop_back());
    end
  endtask
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi, output int lat);
    @(negedge clk);
    a = x;
    b = y;
    b_in = bi;
    start = 1'b1;
    sb.push_back(model(x, y, bi));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    b_in = 1'($urandom);
    wait_done(lat);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, b_out, diff} !== '0) begin
      miscompares++;
      $display("FAIL reset: got busy=%0b done=%0b b_out=%0b diff=%h, expected all 0", busy, done, b_out, diff);
    end
    rst = 1'b0;
  endtask
  task automatic test_directed();
    int lat;
    do_op(16'h1234, 16'h0034, 1'b0, lat);
    vectors++;
    if (lat !== W) begin
      miscompares++;
      $display("FAIL latency: done after %0d RUN edges, expected %0d", lat, W);
    end
    do_op(16'h0000, 16'h0001, 1'b0, lat);
    do_op(16'h8000, 16'h7FFF, 1'b1, lat);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, lat);
  endtask
  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a = 16'hA5A5;
    b = 16'h1111;
    b_in = 1'b0;
    start = 1'b1;
    sb.push_back(model(16'hA5A5, 16'h1111, 1'b0));
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    a = 16'h0100;
    b = 16'h0200;
    b_in = 1'b1;
    sb.push_back(model(16'h0100, 16'h0200, 1'b1));
    wait_done(lat);
    @(posedge clk);
    #1;
    start = 1'b0;
    vectors++;
    if ({busy, done} !== 2'b10) begin
      miscompares++;
      $display("FAIL back_to_back: got busy=%0b done=%0b after DONE-cycle start, expected busy=1 done=0", busy, done);
    end
    wait_done(lat);
  endtask
  task automatic test_reset_mid_run();
    int lat;
    bit saw_done = 0;
    @(negedge clk);
    a = 16'h7777;
    b = 16'h1234;
    b_in = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, diff} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_run: got busy=%0b done=%0b diff=%h, expected all 0", busy, done, diff);
    end
    repeat (W + 4) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abandoned_done: got done pulse %0b after mid-run reset, expected 0", saw_done);
    end
    do_op(16'h0005, 16'h0003, 1'b0, lat);
  endtask
  task automatic test_random();
    int lat;
    for (int i = 0; i < 1000; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), lat);
  endtask
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
